// File: rtl/sdram_arbiter.sv
// Two-port round-robin burst arbiter in front of an Avalon-style SDRAM controller port.
// Each accepted word is one controller command; read returns are steered home by a tag FIFO.
module sdram_arbiter #(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 8,
   parameter int TAG_DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    p0_req,
   input  logic                    p0_wr,
   input  logic [ADDR_WIDTH-1:0]   p0_addr,
   input  logic [LEN_WIDTH-1:0]    p0_len,
   input  logic [DATA_WIDTH-1:0]   p0_wdata,
   output logic                    p0_wack,
   output logic [DATA_WIDTH-1:0]   p0_rdata,
   output logic                    p0_rvalid,
   output logic                    p0_done,
   input  logic                    p1_req,
   input  logic                    p1_wr,
   input  logic [ADDR_WIDTH-1:0]   p1_addr,
   input  logic [LEN_WIDTH-1:0]    p1_len,
   input  logic [DATA_WIDTH-1:0]   p1_wdata,
   output logic                    p1_wack,
   output logic [DATA_WIDTH-1:0]   p1_rdata,
   output logic                    p1_rvalid,
   output logic                    p1_done,
   output logic [ADDR_WIDTH-1:0]   az_addr,
   output logic [DATA_WIDTH-1:0]   az_data,
   output logic [DATA_WIDTH/8-1:0] az_be_n,
   output logic                    az_cs,
   output logic                    az_rd_n,
   output logic                    az_wr_n,
   input  logic [DATA_WIDTH-1:0]   za_data,
   input  logic                    za_valid,
   input  logic                    za_waitrequest,
   output logic                    orphan_err
);
   localparam int TAG_AW = $clog2(TAG_DEPTH);
   localparam logic [TAG_AW:0] TAG_FULL = (TAG_AW+1)'(TAG_DEPTH);

   typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_owner_q, last_owner_d;
   logic                  cur_wr_q, cur_wr_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_WIDTH-1:0]  cur_len_q, cur_len_d;
   logic [1:0]            done_q, done_d;

   logic [1:0]            req_eff;
   logic                  grant;
   logic                  cmd_valid, cmd_accept;

   logic                  tag_mem_q [TAG_DEPTH];
   logic [TAG_AW-1:0]     tag_wr_ptr_q, tag_rd_ptr_q;
   logic [TAG_AW:0]       tag_cnt_q;
   logic                  tag_full, tag_empty, tag_push, tag_pop, tag_head;

   logic [1:0]            rvalid_q;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;
   logic                  orphan_q;

   // A port whose done pulse is showing still has req high; masking it stops a stale re-grant.
   assign req_eff = {p1_req & ~done_q[1], p0_req & ~done_q[0]};
   assign grant   = (req_eff == 2'b11) ? ~last_owner_q : req_eff[1];

   assign cmd_valid  = (state_q == ST_ISSUE) && (cur_wr_q || !tag_full);
   assign cmd_accept = cmd_valid && !za_waitrequest;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cur_wr_q     <= 1'b0;
         cur_addr_q   <= '0;
         cur_len_q    <= '0;
         done_q       <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cur_wr_q     <= cur_wr_d;
         cur_addr_q   <= cur_addr_d;
         cur_len_q    <= cur_len_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cur_wr_d     = cur_wr_q;
      cur_addr_d   = cur_addr_q;
      cur_len_d    = cur_len_q;
      done_d       = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_eff != 2'b00) begin
               owner_d      = grant;
               last_owner_d = grant;
               cur_wr_d     = grant ? p1_wr   : p0_wr;
               cur_addr_d   = grant ? p1_addr : p0_addr;
               cur_len_d    = grant ? p1_len  : p0_len;
               if (cur_len_d == '0) done_d[grant] = 1'b1;
               else                 state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_accept) begin
               cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
               cur_len_d  = cur_len_q - LEN_WIDTH'(1);
               if (cur_len_q == LEN_WIDTH'(1)) begin
                  done_d[owner_q] = 1'b1;
                  state_d         = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign az_cs   = cmd_valid;
   assign az_rd_n = ~(cmd_valid & ~cur_wr_q);
   assign az_wr_n = ~(cmd_valid & cur_wr_q);
   assign az_addr = cur_addr_q;
   assign az_data = (cmd_valid && cur_wr_q) ? (owner_q ? p1_wdata : p0_wdata) : '0;
   assign az_be_n = '0;

   assign p0_wack = cmd_accept & cur_wr_q & ~owner_q;
   assign p1_wack = cmd_accept & cur_wr_q & owner_q;
   assign p0_done = done_q[0];
   assign p1_done = done_q[1];

   // In-flight read tags: one owner bit per outstanding read, in command order.
   assign tag_full  = (tag_cnt_q == TAG_FULL);
   assign tag_empty = (tag_cnt_q == '0);
   assign tag_push  = cmd_accept & ~cur_wr_q;
   assign tag_pop   = za_valid & ~tag_empty;
   assign tag_head  = tag_mem_q[tag_rd_ptr_q];

   // NOTE: tag storage carries no reset; the count and pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (tag_push) tag_mem_q[tag_wr_ptr_q] <= owner_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_wr_ptr_q <= '0;
         tag_rd_ptr_q <= '0;
         tag_cnt_q    <= '0;
         rvalid_q     <= '0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
         orphan_q     <= 1'b0;
      end else begin
         if (tag_push) tag_wr_ptr_q <= tag_wr_ptr_q + TAG_AW'(1);
         if (tag_pop)  tag_rd_ptr_q <= tag_rd_ptr_q + TAG_AW'(1);
         unique case ({tag_push, tag_pop})
            2'b10:   tag_cnt_q <= tag_cnt_q + (TAG_AW+1)'(1);
            2'b01:   tag_cnt_q <= tag_cnt_q - (TAG_AW+1)'(1);
            default: tag_cnt_q <= tag_cnt_q;
         endcase
         rvalid_q <= '0;
         if (tag_pop) begin
            rvalid_q[tag_head] <= 1'b1;
            if (tag_head) p1_rdata_q <= za_data;
            else          p0_rdata_q <= za_data;
         end
         if (za_valid && tag_empty) orphan_q <= 1'b1;
      end
   end

   assign p0_rvalid  = rvalid_q[0];
   assign p1_rvalid  = rvalid_q[1];
   assign p0_rdata   = p0_rdata_q;
   assign p1_rdata   = p1_rdata_q;
   assign orphan_err = orphan_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: requesters push expected commands/returns, a monitor
// compares every accepted command and every read return; a controller model answers reads.
module tb_sdram_arbiter;
   localparam int AW = 22, DW = 16, LW = 8, TD = 8;

   typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
   typedef struct { int due; logic [DW-1:0] data; } ret_t;

   logic clk = 1'b0, reset = 1'b1;
   logic p0_req = 1'b0, p0_wr = 1'b0, p1_req = 1'b0, p1_wr = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [LW-1:0] p0_len = '0, p1_len = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic p0_wack, p1_wack, p0_rvalid, p1_rvalid, p0_done, p1_done;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic [AW-1:0] az_addr;
   logic [DW-1:0] az_data;
   logic [DW/8-1:0] az_be_n;
   logic az_cs, az_rd_n, az_wr_n;
   logic [DW-1:0] za_data = '0;
   logic za_valid = 1'b0, za_waitrequest = 1'b0;
   logic orphan_err;

   always #5 clk = ~clk;

   sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_len(p0_len), .p0_wdata(p0_wdata),
      .p0_wack(p0_wack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_done(p0_done),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_len(p1_len), .p1_wdata(p1_wdata),
      .p1_wack(p1_wack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_done(p1_done),
      .az_addr(az_addr), .az_data(az_data), .az_be_n(az_be_n), .az_cs(az_cs),
      .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .za_data(za_data), .za_valid(za_valid),
      .za_waitrequest(za_waitrequest), .orphan_err(orphan_err)
   );

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   cmd_t exp_cmd [2][$];
   int exp_len [2][$];
   logic [DW-1:0] exp_rd [2][$];
   ret_t ret_q [$];
   int exp_seq [2] = '{0, 0};
   bit zero_len [2] = '{0, 0};
   bit done_exp [2] = '{0, 0};
   int acc_cnt [2] = '{0, 0};
   int rv_cnt [2] = '{0, 0};
   int cs_cnt = 0;
   int burst_order [$];
   int acc_cycles [$];
   int cur_owner = -1, rem = 0, last_due = 0;
   int wmode = 0, lat_min = 3, lat_max = 3, kpat = 0;
   bit withhold = 0, one_shot = 0, inject_orphan = 0, bg_done = 0;
   bit prev_stall = 0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   logic [1:0] prev_strb;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Contents of the modelled SDRAM: a fixed scramble of the word address.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] x;
      x = {10'd0, a} * 32'd40503;
      return x[DW+3:4];
   endfunction

   function automatic bit head_match(input int p, input cmd_t c);
      if (exp_cmd[p].size() == 0) return 1'b0;
      return (exp_cmd[p][0].addr == c.addr) && (exp_cmd[p][0].wr == c.wr);
   endfunction

   // Controller model: waitrequest pattern and in-order read returns.
   initial begin : controller
      ret_t r;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (wmode)
            1: za_waitrequest = ($urandom_range(0, 3) == 0);
            2: begin
               if (az_cs) begin
                  za_waitrequest = (kpat != 2);
                  kpat = (kpat == 2) ? 0 : kpat + 1;
               end else begin
                  za_waitrequest = 1'b0;
                  kpat = 0;
               end
            end
            default: za_waitrequest = 1'b0;
         endcase
         za_valid = 1'b0;
         if (inject_orphan) begin
            za_valid = 1'b1;
            za_data = 16'hDEAD;
            inject_orphan = 0;
         end else if (ret_q.size() > 0 && ret_q[0].due <= cyc && (!withhold || one_shot)) begin
            r = ret_q.pop_front();
            za_valid = 1'b1;
            za_data = r.data;
            one_shot = 0;
         end
      end
   end

   // Show-ahead write sources: word = {port, sequence}, advanced after each wack.
   initial begin : wsources
      int s0 = 0, s1 = 0;
      bit w0, w1;
      forever begin
         @(negedge clk);
         w0 = p0_wack;
         w1 = p1_wack;
         @(posedge clk);
         #1;
         if (w0) s0++;
         if (w1) s1++;
         p0_wdata = {1'b0, 15'(s0)};
         p1_wdata = {1'b1, 15'(s1)};
      end
   end

   initial begin : monitor
      cmd_t c, e;
      int o, due;
      logic dn, rv, acc;
      logic [DW-1:0] rd;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int n = 0; n < 2; n++) begin
               dn = n ? p1_done : p0_done;
               rv = n ? p1_rvalid : p0_rvalid;
               rd = n ? p1_rdata : p0_rdata;
               if (!zero_len[n] && (dn || done_exp[n])) check($sformatf("p%0d_done", n), dn, done_exp[n]);
               done_exp[n] = 0;
               if (rv) begin
                  rv_cnt[n]++;
                  if (exp_rd[n].size() == 0) check($sformatf("p%0d_rvalid_unexpected", n), 1, 0);
                  else check($sformatf("p%0d_rdata", n), rd, exp_rd[n].pop_front());
               end
            end
            if (az_cs) begin
               cs_cnt++;
               check("strobe_exclusive", az_rd_n ^ az_wr_n, 1);
            end else if (!(az_rd_n && az_wr_n)) check("strobe_idle", {az_rd_n, az_wr_n}, 2'b11);
            if (az_be_n != '0) check("az_be_n", az_be_n, 0);
            if (prev_stall && az_cs) begin
               check("stall_addr", az_addr, prev_addr);
               check("stall_data", az_data, prev_data);
               check("stall_strobe", {az_rd_n, az_wr_n}, prev_strb);
            end
            acc = az_cs && !za_waitrequest;
            if (acc) begin
               c.wr = !az_wr_n;
               c.addr = az_addr;
               c.data = az_data;
               o = -1;
               if (cur_owner >= 0) o = cur_owner;
               else if (head_match(0, c)) o = 0;
               else if (head_match(1, c)) o = 1;
               if (o < 0 || exp_cmd[o].size() == 0) begin
                  check("cmd_unexpected", c.addr, {1'b1, 63'd0});
               end else begin
                  e = exp_cmd[o].pop_front();
                  check("cmd_addr", c.addr, e.addr);
                  check("cmd_wr", c.wr, e.wr);
                  if (e.wr) check("cmd_wdata", c.data, e.data);
                  check("wack_owner", o ? p1_wack : p0_wack, e.wr);
                  check("wack_other", o ? p0_wack : p1_wack, 0);
                  if (cur_owner < 0) begin
                     rem = (exp_len[o].size() > 0) ? exp_len[o].pop_front() : 1;
                     cur_owner = o;
                     burst_order.push_back(o);
                  end
                  rem--;
                  acc_cnt[o]++;
                  acc_cycles.push_back(cyc);
                  if (!e.wr) begin
                     exp_rd[o].push_back(mem_word(c.addr));
                     due = cyc + $urandom_range(lat_min, lat_max);
                     if (due <= last_due) due = last_due + 1;
                     last_due = due;
                     ret_q.push_back('{due, mem_word(c.addr)});
                  end
                  if (rem == 0) begin
                     done_exp[o] = 1;
                     cur_owner = -1;
                  end
               end
            end else if (p0_wack || p1_wack) check("wack_spurious", {p1_wack, p0_wack}, 0);
            prev_stall = az_cs && za_waitrequest;
            prev_addr = az_addr;
            prev_data = az_data;
            prev_strb = {az_rd_n, az_wr_n};
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      ret_q.delete();
      for (int n = 0; n < 2; n++) begin
         exp_cmd[n].delete();
         exp_len[n].delete();
         exp_rd[n].delete();
         done_exp[n] = 0;
      end
      cur_owner = -1;
      rem = 0;
      last_due = 0;
      prev_stall = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic burst(input int p, input bit wr, input logic [AW-1:0] addr, input int len);
      cmd_t c;
      bit seen;
      for (int i = 0; i < len; i++) begin
         c.wr = wr;
         c.addr = addr + AW'(i);
         c.data = wr ? {p[0], 15'(exp_seq[p] + i)} : '0;
         exp_cmd[p].push_back(c);
      end
      if (wr) exp_seq[p] += len;
      if (len > 0) exp_len[p].push_back(len);
      else zero_len[p] = 1;
      @(posedge clk);
      #1;
      if (p == 0) begin p0_req = 1; p0_wr = wr; p0_addr = addr; p0_len = LW'(len); end
      else        begin p1_req = 1; p1_wr = wr; p1_addr = addr; p1_len = LW'(len); end
      seen = 0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         seen = (p == 0) ? p0_done : p1_done;
      end
      check($sformatf("p%0d_done_seen", p), seen, 1);
      @(posedge clk);
      #1;
      if (p == 0) p0_req = 0; else p1_req = 0;
      zero_len[p] = 0;
   endtask

   task automatic rand_burst(input int p);
      logic [AW-1:0] a;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = AW'($urandom_range(0, 20'hFFFFF)) | (p ? AW'(22'h200000) : AW'(0));
      burst(p, 1'($urandom_range(0, 1)), a, $urandom_range(1, 20));
   endtask

   task automatic wait_drain();
      int i = 0;
      while ((ret_q.size() > 0 || exp_rd[0].size() > 0 || exp_rd[1].size() > 0) && i < 2000) begin
         @(negedge clk);
         i++;
      end
      check("drain_timeout", i < 2000, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int a0, a1, r0, r1, cs0;
      do_reset();
      @(negedge clk);
      check("rst_az_cs", az_cs, 0);
      check("rst_strobes", {az_rd_n, az_wr_n}, 2'b11);
      check("rst_az_addr_data", {az_addr, az_data}, 0);
      check("rst_az_be_n", az_be_n, 0);
      check("rst_port_pulses", {p0_wack, p1_wack, p0_rvalid, p1_rvalid, p0_done, p1_done}, 0);
      check("rst_rdata", {p0_rdata, p1_rdata}, 0);
      check("rst_orphan", orphan_err, 0);

      // Read return with nothing outstanding.
      r0 = rv_cnt[0] + rv_cnt[1];
      inject_orphan = 1;
      repeat (4) @(negedge clk);
      check("orphan_set", orphan_err, 1);
      check("orphan_no_rvalid", rv_cnt[0] + rv_cnt[1], r0);

      // Zero-length request: done only, no command.
      cs0 = cs_cnt;
      burst(0, 1, 22'h000040, 0);
      check("len0_no_cs", cs_cnt, cs0);
      check("orphan_sticky", orphan_err, 1);

      // Both requesting from reset: strict alternation.
      do_reset();
      check("orphan_cleared", orphan_err, 0);
      burst_order.delete();
      fork
         begin burst(0, 1, 22'h000200, 2); burst(0, 1, 22'h000210, 2); end
         begin burst(1, 1, 22'h200300, 2); burst(1, 1, 22'h200310, 2); end
      join
      check("alt_count", burst_order.size(), 4);
      for (int k = 0; k < burst_order.size(); k++) check($sformatf("alt_order%0d", k), burst_order[k], k % 2);

      // Port 0 write burst, no stalls.
      a0 = acc_cnt[0];
      burst(0, 1, 22'h000100, 4);
      check("wr4_accepts", acc_cnt[0] - a0, 4);

      // Port 1 read crossing the top of the address space, latency 3.
      r0 = rv_cnt[0];
      r1 = rv_cnt[1];
      lat_min = 3;
      lat_max = 3;
      burst(1, 0, 22'h3FFFFE, 4);
      wait_drain();
      check("rd_wrap_p1_rvalid", rv_cnt[1] - r1, 4);
      check("rd_wrap_p0_rvalid", rv_cnt[0] - r0, 0);

      // Waitrequest 1,1,0 on every write word.
      wmode = 2;
      acc_cycles.delete();
      burst(0, 1, 22'h000700, 4);
      wmode = 0;
      check("stall_accepts", acc_cycles.size(), 4);
      for (int k = 1; k < acc_cycles.size(); k++) check($sformatf("stall_gap%0d", k), acc_cycles[k] - acc_cycles[k-1], 3);

      // Tag FIFO full: returns withheld.
      a1 = acc_cnt[1];
      lat_min = 2;
      lat_max = 2;
      withhold = 1;
      bg_done = 0;
      fork
         begin burst(1, 0, 22'h200500, 16); bg_done = 1; end
      join_none
      repeat (30) @(negedge clk);
      check("full_accepts", acc_cnt[1] - a1, TD);
      check("full_cs_low", az_cs, 0);
      one_shot = 1;
      repeat (10) @(negedge clk);
      check("full_one_more", acc_cnt[1] - a1, TD + 1);
      check("full_cs_low_again", az_cs, 0);
      withhold = 0;
      for (int i = 0; i < 2000 && !bg_done; i++) @(negedge clk);
      check("full_burst_finished", bg_done, 1);
      wait_drain();

      // Randomized contention with random stalls and return latency.
      wmode = 1;
      lat_min = 1;
      lat_max = 6;
      fork
         begin for (int k = 0; k < 12; k++) rand_burst(0); end
         begin for (int j = 0; j < 12; j++) rand_burst(1); end
      join
      wmode = 0;
      wait_drain();

      check("end_cmd_queues_empty", exp_cmd[0].size() + exp_cmd[1].size(), 0);
      check("end_orphan", orphan_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
